stage_mem: RTL and testbench



---
 rtl/mips_cpu_pkg.sv | 28 ++
 rtl/mem_align.sv | 61 ++++++
 rtl/stage_mem.sv | 142 ++++++++++++++
 tb/tb_stage_mem.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: machine word, multiplier result, register names, and the
// MEM-stage access size and FSM state enumerations.
package mips_cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] double_word_t;

    typedef enum logic [4:0] {
        REG_ZERO, REG_AT, REG_V0, REG_V1, REG_A0, REG_A1, REG_A2, REG_A3,
        REG_T0,   REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
        REG_S0,   REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
        REG_T8,   REG_T9, REG_K0, REG_K1, REG_GP, REG_SP, REG_FP, REG_RA
    } reg_enum;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_enum;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_WAIT,
        MEM_DONE
    } mem_state_enum;

endpackage

// File: rtl/mem_align.sv
// Data-memory lane logic for the MEM stage (purely combinational).
//   size_i, addr_i   : access size and low address bits
//   signed_i         : sign-extend (lb/lh) vs zero-extend (lbu/lhu) loads
//   rtdata_i         : store data; wdata_o/be_o are the lane-replicated bus data
//   rdata_i          : raw bus read data; ldata_o is aligned and extended
//   misaligned_o     : H with addr[0] set, or W with addr[1:0] non-zero
module mem_align
    import mips_cpu_pkg::*;
(
    input  mem_size_enum size_i,
    input  logic         signed_i,
    input  logic [1:0]   addr_i,
    input  word_t        rtdata_i,
    input  word_t        rdata_i,
    output logic [3:0]   be_o,
    output word_t        wdata_o,
    output word_t        ldata_o,
    output logic         misaligned_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        unique case (addr_i)
            2'd0:    rd_byte = rdata_i[7:0];
            2'd1:    rd_byte = rdata_i[15:8];
            2'd2:    rd_byte = rdata_i[23:16];
            default: rd_byte = rdata_i[31:24];
        endcase
        rd_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = rtdata_i;
        ldata_o      = rdata_i;
        misaligned_o = 1'b0;
        case (size_i)
            MEM_B: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{rtdata_i[7:0]}};
                ldata_o = {{24{signed_i & rd_byte[7]}}, rd_byte};
            end
            MEM_H: begin
                be_o         = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{rtdata_i[15:0]}};
                ldata_o      = {{16{signed_i & rd_half[15]}}, rd_half};
                misaligned_o = addr_i[0];
            end
            MEM_W: begin
                be_o         = 4'b1111;
                misaligned_o = |addr_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Pipeline MEM stage: issues loads/stores on a req/gnt/rvalid data bus, stalls
// the pipeline while an access is outstanding, and drives the MEM/WB register.
//   clk, rst_n         : clock, asynchronous active-low reset
//   mem_i_*            : EX/MEM register outputs (held stable while stall=1)
//   mem_o_*            : MEM/WB inputs; dmdout is registered, the rest pass through
//   mem_o_adel/ades    : misaligned load/store, combinational
//   stall              : freeze IF..MEM and bubble MEM/WB
//   dm_*               : data-memory bus
module stage_mem
    import mips_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_i_dmre,
    input  logic              mem_i_dmwe,
    input  logic              mem_i_signed,
    input  mem_size_enum      mem_i_size,
    input  word_t             mem_i_alures,
    input  word_t             mem_i_rtdata,
    input  logic              mem_i_dm2rf,
    input  logic              mem_i_hilowe,
    input  logic              mem_i_rfwe,
    input  reg_enum           mem_i_rfwa,
    input  double_word_t      mem_i_mulres,
    output logic              mem_o_dm2rf,
    output logic              mem_o_hilowe,
    output logic              mem_o_rfwe,
    output reg_enum           mem_o_rfwa,
    output double_word_t      mem_o_mulres,
    output word_t             mem_o_alures,
    output logic [3:0]        mem_o_bytesel,
    output word_t             mem_o_dmdout,
    output logic              mem_o_adel,
    output logic              mem_o_ades,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_be,
    output logic [ADDR_W-1:0] dm_addr,
    output word_t             dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  word_t             dm_rdata
);

    mem_state_enum state_q;
    word_t         dmdout_q;

    logic       misaligned;
    logic       go;
    logic [3:0] lane_be;
    word_t      lane_wdata;
    word_t      load_data;

    mem_align u_mem_align (
        .size_i       (mem_i_size),
        .signed_i     (mem_i_signed),
        .addr_i       (mem_i_alures[1:0]),
        .rtdata_i     (mem_i_rtdata),
        .rdata_i      (dm_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .ldata_o      (load_data),
        .misaligned_o (misaligned)
    );

    // Only aligned accesses ever reach the bus.
    assign go = (mem_i_dmre | mem_i_dmwe) & ~misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MEM_IDLE;
            dmdout_q <= '0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (go) begin
                        if (dm_gnt) state_q <= mem_i_dmre ? MEM_WAIT : MEM_DONE;
                        else        state_q <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (dm_gnt) state_q <= mem_i_dmre ? MEM_WAIT : MEM_DONE;
                end
                MEM_WAIT: begin
                    if (dm_rvalid) begin
                        dmdout_q <= load_data;
                        state_q  <= MEM_DONE;
                    end
                end
                default: begin
                    state_q <= MEM_IDLE;
                end
            endcase
        end
    end

    // Request and stall decode the incoming access in IDLE so a zero-wait
    // memory can grant in the very first cycle of the instruction.
    always_comb begin
        dm_req = 1'b0;
        stall  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                dm_req = go;
                stall  = go;
            end
            MEM_REQ: begin
                dm_req = 1'b1;
                stall  = 1'b1;
            end
            MEM_WAIT: begin
                stall = 1'b1;
            end
            default: begin
                dm_req = 1'b0;
                stall  = 1'b0;
            end
        endcase
    end

    // Bus data derives from EX/MEM, which is frozen while stalled, so it is
    // stable for the whole request phase.
    assign dm_we    = dm_req & mem_i_dmwe;
    assign dm_be    = dm_req ? lane_be : 4'b0000;
    assign dm_addr  = {mem_i_alures[ADDR_W-1:2], 2'b00};
    assign dm_wdata = lane_wdata;

    assign mem_o_dm2rf   = mem_i_dm2rf;
    assign mem_o_hilowe  = mem_i_hilowe;
    assign mem_o_rfwa    = mem_i_rfwa;
    assign mem_o_mulres  = mem_i_mulres;
    assign mem_o_alures  = mem_i_alures;
    assign mem_o_rfwe    = mem_i_rfwe & ~(mem_i_dmre & misaligned);
    assign mem_o_bytesel = mem_i_dmre ? 4'b1111 : 4'b0000;
    assign mem_o_dmdout  = dmdout_q;
    assign mem_o_adel    = mem_i_dmre & misaligned;
    assign mem_o_ades    = mem_i_dmwe & misaligned;

endmodule

// File: tb/tb_stage_mem.sv
// Randomized self-checking bench for stage_mem. The bench plays the data
// memory with configurable grant/rvalid latency and predicts every output from
// the access rules using plain arithmetic.
module tb_stage_mem;
    import mips_cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_i_dmre, mem_i_dmwe, mem_i_signed;
    mem_size_enum mem_i_size;
    word_t        mem_i_alures, mem_i_rtdata;
    logic         mem_i_dm2rf, mem_i_hilowe, mem_i_rfwe;
    reg_enum      mem_i_rfwa;
    double_word_t mem_i_mulres;
    logic         mem_o_dm2rf, mem_o_hilowe, mem_o_rfwe;
    reg_enum      mem_o_rfwa;
    double_word_t mem_o_mulres;
    word_t        mem_o_alures, mem_o_dmdout;
    logic [3:0]   mem_o_bytesel;
    logic         mem_o_adel, mem_o_ades, stall;
    logic         dm_req, dm_we;
    logic [3:0]   dm_be;
    logic [31:0]  dm_addr;
    word_t        dm_wdata;
    logic         dm_gnt, dm_rvalid;
    word_t        dm_rdata;

    int    n_tests = 0;
    int    n_fail = 0;
    word_t last_load = '0;

    always #5 clk = ~clk;

    stage_mem #(.ADDR_W(32)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_i_dmre    (mem_i_dmre),
        .mem_i_dmwe    (mem_i_dmwe),
        .mem_i_signed  (mem_i_signed),
        .mem_i_size    (mem_i_size),
        .mem_i_alures  (mem_i_alures),
        .mem_i_rtdata  (mem_i_rtdata),
        .mem_i_dm2rf   (mem_i_dm2rf),
        .mem_i_hilowe  (mem_i_hilowe),
        .mem_i_rfwe    (mem_i_rfwe),
        .mem_i_rfwa    (mem_i_rfwa),
        .mem_i_mulres  (mem_i_mulres),
        .mem_o_dm2rf   (mem_o_dm2rf),
        .mem_o_hilowe  (mem_o_hilowe),
        .mem_o_rfwe    (mem_o_rfwe),
        .mem_o_rfwa    (mem_o_rfwa),
        .mem_o_mulres  (mem_o_mulres),
        .mem_o_alures  (mem_o_alures),
        .mem_o_bytesel (mem_o_bytesel),
        .mem_o_dmdout  (mem_o_dmdout),
        .mem_o_adel    (mem_o_adel),
        .mem_o_ades    (mem_o_ades),
        .stall         (stall),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_be         (dm_be),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_misal(input mem_size_enum sz, input word_t addr);
        return (sz == MEM_H && addr % 2 != 0) || (sz == MEM_W && addr % 4 != 0);
    endfunction

    function automatic logic [3:0] exp_be(input mem_size_enum sz, input word_t addr);
        int off;
        off = int'(addr % 4);
        if (sz == MEM_B) return 4'(1 << off);
        if (sz == MEM_H) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic word_t exp_wdata(input mem_size_enum sz, input word_t rt);
        if (sz == MEM_B) return (rt % 256) * 32'h0101_0101;
        if (sz == MEM_H) return (rt % 65536) * 32'h0001_0001;
        return rt;
    endfunction

    function automatic word_t exp_load(input mem_size_enum sz, input logic sgn,
                                       input word_t addr, input word_t rd);
        word_t v;
        v = rd >> (8 * (addr % 4));
        if (sz == MEM_B) begin
            v = v % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (sz == MEM_H) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // op: 0 = non-memory, 1 = load, 2 = store.
    task automatic drive(input int op, input mem_size_enum sz, input logic sgn,
                         input word_t addr, input word_t rt);
        mem_i_dmre   = (op == 1);
        mem_i_dmwe   = (op == 2);
        mem_i_signed = sgn;
        mem_i_size   = sz;
        mem_i_alures = addr;
        mem_i_rtdata = rt;
        mem_i_dm2rf  = 1'($urandom);
        mem_i_hilowe = 1'($urandom);
        mem_i_rfwe   = 1'($urandom);
        mem_i_rfwa   = reg_enum'(5'($urandom));
        mem_i_mulres = {$urandom, $urandom};
    endtask

    task automatic check_pass(input logic exp_rfwe);
        check("dm2rf", 64'(mem_o_dm2rf), 64'(mem_i_dm2rf));
        check("hilowe", 64'(mem_o_hilowe), 64'(mem_i_hilowe));
        check("rfwa", 64'(mem_o_rfwa), 64'(mem_i_rfwa));
        check("mulres", mem_o_mulres, mem_i_mulres);
        check("alures", 64'(mem_o_alures), 64'(mem_i_alures));
        check("rfwe", 64'(mem_o_rfwe), 64'(exp_rfwe));
    endtask

    task automatic run_txn(input int op, input mem_size_enum sz, input logic sgn,
                           input word_t addr, input word_t rt, input int gdly,
                           input int rdly, input word_t rdata, output int stalls);
        logic  mis, active, done, p_rfwe;
        int    phase, req_cnt, wait_cnt, cyc, exp_stalls;
        drive(op, sz, sgn, addr, rt);
        p_rfwe   = mem_i_rfwe;
        mis      = (op != 0) && exp_misal(sz, addr);
        active   = (op != 0) && !mis;
        phase    = active ? 0 : 2;
        req_cnt  = 0;
        wait_cnt = 0;
        stalls   = 0;
        cyc      = 0;
        done     = 1'b0;
        while (!done && cyc < 64) begin
            dm_gnt    = 1'b0;
            dm_rvalid = 1'b0;
            dm_rdata  = $urandom;
            #1;
            check_pass(p_rfwe && !(op == 1 && mis));
            if (stall) stalls++;
            if (phase == 0) begin
                check("stall_req", 64'(stall), 64'(1));
                check("dm_req", 64'(dm_req), 64'(1));
                check("dm_addr", 64'(dm_addr), 64'(addr - addr % 4));
                check("dm_we", 64'(dm_we), 64'(op == 2));
                if (op == 2) begin
                    check("dm_be", 64'(dm_be), 64'(exp_be(sz, addr)));
                    check("dm_wdata", 64'(dm_wdata), 64'(exp_wdata(sz, rt)));
                end
                if (req_cnt == gdly) begin
                    dm_gnt = 1'b1;
                    phase  = (op == 1) ? 1 : 2;
                end else begin
                    req_cnt++;
                    dm_rvalid = 1'($urandom);
                end
            end else if (phase == 1) begin
                check("stall_wait", 64'(stall), 64'(1));
                check("req_wait", 64'(dm_req), 64'(0));
                if (wait_cnt == rdly) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = rdata;
                    phase     = 2;
                end else begin
                    wait_cnt++;
                end
            end else begin
                check("stall_done", 64'(stall), 64'(0));
                check("req_done", 64'(dm_req), 64'(0));
                if (active && op == 1) last_load = exp_load(sz, sgn, addr, rdata);
                check("dmdout", 64'(mem_o_dmdout), 64'(last_load));
                check("bytesel", 64'(mem_o_bytesel), (op == 1) ? 64'hF : 64'h0);
                check("adel", 64'(mem_o_adel), 64'(op == 1 && mis));
                check("ades", 64'(mem_o_ades), 64'(op == 2 && mis));
                // Stray handshakes outside REQ/WAIT must be ignored.
                dm_gnt    = 1'($urandom);
                dm_rvalid = 1'($urandom);
                done      = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("txn_timeout", 64'(done), 64'(1));
        exp_stalls = active ? (gdly + 1 + ((op == 1) ? rdly + 1 : 0)) : 0;
        check("stall_cnt", 64'(stalls), 64'(exp_stalls));
    endtask

    initial begin
        int st;
        drive(0, MEM_W, 1'b0, 32'h0, 32'h0);
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        #2;
        check("rst_dmdout", 64'(mem_o_dmdout), 64'(0));
        check("rst_req", 64'(dm_req), 64'(0));
        check("rst_we", 64'(dm_we), 64'(0));
        check("rst_be", 64'(dm_be), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(1, MEM_W, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, st);
        check("lw_stall2", 64'(st), 64'(2));
        check("lw_data", 64'(mem_o_dmdout), 64'h0000_0000_DEAD_BEEF);
        run_txn(1, MEM_B, 1'b1, 32'h103, 32'h0, 0, 0, 32'h8011_2233, st);
        check("lb_signed", 64'(mem_o_dmdout), 64'h0000_0000_FFFF_FF80);
        run_txn(1, MEM_B, 1'b0, 32'h103, 32'h0, 0, 0, 32'h8011_2233, st);
        check("lbu", 64'(mem_o_dmdout), 64'h0000_0000_0000_0080);
        run_txn(2, MEM_H, 1'b0, 32'h102, 32'h0000_ABCD, 3, 0, 32'h0, st);
        check("sh_stall4", 64'(st), 64'(4));
        run_txn(1, MEM_W, 1'b0, 32'h101, 32'h0, 0, 0, 32'h0, st);
        run_txn(0, MEM_W, 1'b0, 32'h1234_5678, 32'h0, 0, 0, 32'h0, st);

        // Reset while waiting for read data.
        drive(1, MEM_W, 1'b0, 32'h200, 32'h0);
        #1;
        dm_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dm_gnt = 1'b0;
        #1;
        check("wait_stall", 64'(stall), 64'(1));
        check("wait_req", 64'(dm_req), 64'(0));
        drive(0, MEM_W, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 64'(dm_req), 64'(0));
        check("mid_rst_stall", 64'(stall), 64'(0));
        check("mid_rst_dmdout", 64'(mem_o_dmdout), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_load = '0;
        run_txn(1, MEM_W, 1'b0, 32'h200, 32'h0, 1, 2, 32'h1357_9BDF, st);
        check("post_rst_lw", 64'(mem_o_dmdout), 64'h0000_0000_1357_9BDF);

        for (int i = 0; i < 300; i++) begin
            word_t a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a - a % 4 + word_t'($urandom_range(0, 1)) * 2;
            run_txn(int'($urandom_range(0, 2)), mem_size_enum'($urandom_range(0, 2)),
                    1'($urandom), a, $urandom, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), $urandom, st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
